// File: rtl/sha256_id_credit_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_id_credit_ctrl
// Credit controller between the SHA-256 packet ID issuer and the hash output
// path. It gates issue_en so no more than DEPTH IDs are in flight, keeps the
// issued IDs in an in-order queue, and checks every returned ID against the
// queue head. A mismatch halts issue and raises a sticky error.
//
// Optional feature: define SHA256_ID_CTRL_TIMEOUT_EN to add parameter TIMEOUT
// and a 16-bit age counter that forces ERROR when the head waits too long.
//
// Ports
//   clk, nrst          clock, asynchronous active-low reset
//   sync_rst           synchronous reset, same effect as nrst
//   start/stop/err_clr control pulses
//   issue_en           registered enable to the ID issuer
//   id_in/_valid/_ready    issued ID channel (push into queue)
//   ret_id/_valid/_ready   returned ID channel (pop from queue)
//   expected_id        head of the queue (0 when empty)
//   outstanding        queue occupancy
//   retire_ok/_err     one-cycle retire result pulses
//   busy, err          state is RUN/DRAIN, state is ERROR
// ---------------------------------------------------------------------------
module sha256_id_credit_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 6
`ifdef SHA256_ID_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 1024
`endif
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    sync_rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    err_clr,
  output logic                    issue_en,
  input  logic [ID_W-1:0]         id_in,
  input  logic                    id_in_valid,
  output logic                    id_in_ready,
  input  logic [ID_W-1:0]         ret_id,
  input  logic                    ret_valid,
  output logic                    ret_ready,
  output logic [ID_W-1:0]         expected_id,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    retire_ok,
  output logic                    retire_err,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_nxt;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [ID_W-1:0]    mem [DEPTH];

  logic               issue_nxt;
  logic               ok_nxt;
  logic               err_pulse_nxt;
  logic               busy_nxt;
  logic               err_nxt;

  logic               full_c;
  logic               empty_c;
  logic               push_c;
  logic               pop_c;
  logic               mismatch_c;
  logic               timeout_c;

  // Queue status and handshakes; both channels are closed in ERROR.
  assign full_c      = (cnt_q == CNT_W'(DEPTH));
  assign empty_c     = (cnt_q == '0);
  assign id_in_ready = !full_c && (state_q != S_ERROR);
  assign ret_ready   = !empty_c && (state_q != S_ERROR);
  assign push_c      = id_in_valid && id_in_ready;
  assign pop_c       = ret_valid && ret_ready;
  assign expected_id = empty_c ? '0 : mem[rd_ptr_q];
  assign mismatch_c  = pop_c && (ret_id != expected_id);
  assign outstanding = cnt_q;

`ifdef SHA256_ID_CTRL_TIMEOUT_EN
  // Age of the current head: cleared by a pop or an empty queue, frozen at 0 in ERROR.
  logic [15:0] age_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      age_q <= '0;
    end else if (sync_rst || pop_c || empty_c || (state_q == S_ERROR)) begin
      age_q <= '0;
    end else begin
      age_q <= age_q + 16'(1);
    end
  end

  // Fires on the cycle whose edge would bring the age to TIMEOUT.
  assign timeout_c = !empty_c && !pop_c && (state_q != S_ERROR) &&
                     (age_q == 16'(TIMEOUT - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Queue storage; entries beyond the pointers are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= id_in;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      issue_en   <= 1'b0;
      retire_ok  <= 1'b0;
      retire_err <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      wr_ptr_q   <= wr_ptr_nxt;
      rd_ptr_q   <= rd_ptr_nxt;
      cnt_q      <= cnt_nxt;
      issue_en   <= issue_nxt;
      retire_ok  <= ok_nxt;
      retire_err <= err_pulse_nxt;
      busy       <= busy_nxt;
      err        <= err_nxt;
    end
  end

  // Next-state, queue pointer and output decode.
  always_comb begin
    state_nxt     = state_q;
    wr_ptr_nxt    = wr_ptr_q;
    rd_ptr_nxt    = rd_ptr_q;
    cnt_nxt       = cnt_q;
    ok_nxt        = 1'b0;
    err_pulse_nxt = 1'b0;
    issue_nxt     = 1'b0;
    busy_nxt      = 1'b0;
    err_nxt       = 1'b0;

    if (push_c) begin
      wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      cnt_nxt = cnt_q - CNT_W'(1);
    end

    ok_nxt        = pop_c && !mismatch_c;
    err_pulse_nxt = mismatch_c || timeout_c;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((cnt_nxt == '0) && !push_c) begin
          state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        if (err_clr) begin
          state_nxt  = S_IDLE;
          wr_ptr_nxt = '0;
          rd_ptr_nxt = '0;
          cnt_nxt    = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // A bad return (or an aged-out head) wins over any control pulse.
    if ((state_q != S_ERROR) && (mismatch_c || timeout_c)) begin
      state_nxt = S_ERROR;
    end

    // Local reset discards the queue without any retire pulses.
    if (sync_rst) begin
      state_nxt     = S_IDLE;
      wr_ptr_nxt    = '0;
      rd_ptr_nxt    = '0;
      cnt_nxt       = '0;
      ok_nxt        = 1'b0;
      err_pulse_nxt = 1'b0;
    end

    // One free slot is kept back to cover the issuer's one-cycle latency.
    issue_nxt = (state_nxt == S_RUN) && (cnt_nxt <= CNT_W'(DEPTH - 2));
    busy_nxt  = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
    err_nxt   = (state_nxt == S_ERROR);
  end

endmodule
